// File: rtl/mmm_sequencer_if.sv
// Control/status bundle between the exponentiation controller, the sequencer
// and the Montgomery multiplier control inputs.
interface mmm_sequencer_if #(
   parameter int CNT_W = 11
);
   logic             start;
   logic             abort;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CNT_W-1:0] iter;
   logic             en;
   logic             rst_mmm;
   logic             ld_a;
   logic             ld_r;
   logic             lock;

   // Requester side: issues start/abort, observes status and datapath controls.
   modport master (
      output start, abort,
      input  busy, done, aborted, iter, en, rst_mmm, ld_a, ld_r, lock
   );

   // Sequencer side.
   modport slave (
      input  start, abort,
      output busy, done, aborted, iter, en, rst_mmm, ld_a, ld_r, lock
   );
endinterface

// File: rtl/mmm_sequencer.sv
// Moore sequencer for the Montgomery multiplier: CLEAR, LOAD, NBITS RUN
// iterations, CAPTURE, DONE, with abort into a one-cycle ABORT state.
module mmm_sequencer #(
   parameter int NBITS = 1026,
   parameter int CNT_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   mmm_sequencer_if.slave    bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_RUN,
      S_CAPTURE,
      S_DONE,
      S_ABORT
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NBITS - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] iter_q, iter_nxt;
   logic             aborted_q, aborted_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         iter_q    <= '0;
         aborted_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         iter_q    <= iter_nxt;
         aborted_q <= aborted_nxt;
      end
   end

   // Abort wins over every transition, including the terminal count in RUN.
   always_comb begin
      state_nxt   = state;
      iter_nxt    = iter_q;
      aborted_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start && !bus.abort) state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            state_nxt = bus.abort ? S_ABORT : S_LOAD;
         end
         S_LOAD: begin
            if (bus.abort) begin
               state_nxt = S_ABORT;
            end else begin
               state_nxt = S_RUN;
               iter_nxt  = '0;
            end
         end
         S_RUN: begin
            if (bus.abort) begin
               state_nxt = S_ABORT;
            end else if (iter_q == LAST_ITER) begin
               state_nxt = S_CAPTURE;
            end else begin
               iter_nxt = iter_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            state_nxt = bus.abort ? S_ABORT : S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         S_ABORT: begin
            state_nxt   = S_IDLE;
            aborted_nxt = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.busy    = (state != S_IDLE);
      bus.done    = (state == S_DONE);
      bus.aborted = aborted_q;
      bus.iter    = iter_q;
      bus.en      = 1'b0;
      bus.rst_mmm = 1'b1;
      bus.ld_a    = 1'b0;
      bus.ld_r    = 1'b0;
      bus.lock    = 1'b1;
      case (state)
         S_CLEAR: bus.rst_mmm = 1'b0;
         S_LOAD: begin
            bus.en   = 1'b1;
            bus.ld_a = 1'b1;
         end
         S_RUN: bus.en = 1'b1;
         // Only window in which the result register may change.
         S_CAPTURE: begin
            bus.ld_r = 1'b1;
            bus.lock = 1'b0;
         end
         S_ABORT: bus.rst_mmm = 1'b0;
         default: ;
      endcase
   end

endmodule
